// File: rtl/starter_sel_ctrl.sv
// Round-robin owner of a shared DUT select line: grants one requester a
// fixed-length sel window, then enforces a guard gap before re-arbitrating.
module starter_sel_ctrl #(
    parameter int N_REQ  = 4,
    parameter int HOLD_W = 8,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic [GAP_W-1:0]  gap_len,
    output logic              sel,
    output logic [N_REQ-1:0]  gnt,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [PTR_W-1:0]    ptr_q,     ptr_d;
    logic [HOLD_W-1:0]   act_cnt_q, act_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]    gap_lat_q, gap_lat_d;
    logic                sel_q,     sel_d;
    logic [N_REQ-1:0]    gnt_q,     gnt_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    logic [PTR_W-1:0]    win_idx_s;
    logic                win_found_s;
    logic [PTR_W-1:0]    ptr_inc_s;
    logic [HOLD_W-1:0]   hold_eff_s;

    // Round-robin search starting at ptr_q and wrapping from N_REQ-1 to 0.
    always_comb begin : arb_comb
        int cand;
        cand        = 0;
        win_idx_s   = '0;
        win_found_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr_q) + k) % N_REQ;
            if (!win_found_s && req[cand]) begin
                win_found_s = 1'b1;
                win_idx_s   = PTR_W'(cand);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Pointer advance past the winner and zero-hold promotion to one cycle.
    always_comb begin
        if (win_idx_s == PTR_W'(N_REQ - 1)) begin
            ptr_inc_s = '0;
        end else begin
            ptr_inc_s = win_idx_s + PTR_W'(1);
        end
        if (hold_len == '0) begin
            hold_eff_s = HOLD_W'(1);
        end else begin
            hold_eff_s = hold_len;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every port is driven straight from a flop.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        act_cnt_d = act_cnt_q;
        gap_cnt_d = gap_cnt_q;
        gap_lat_d = gap_lat_q;
        sel_d     = 1'b0;
        gnt_d     = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d          = ST_ACTIVE;
                    ptr_d            = ptr_inc_s;
                    act_cnt_d        = hold_eff_s - HOLD_W'(1);
                    gap_lat_d        = gap_len;
                    sel_d            = 1'b1;
                    gnt_d[win_idx_s] = 1'b1;
                    busy_d           = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACTIVE: begin
                // act_cnt_q counts the ACTIVE cycles still to come after this one.
                if (act_cnt_q == '0) begin
                    done_d = 1'b1;
                    if (gap_lat_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_lat_q - GAP_W'(1);
                        busy_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    act_cnt_d = act_cnt_q - HOLD_W'(1);
                    sel_d     = 1'b1;
                    gnt_d     = gnt_q;
                    busy_d    = 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    busy_d    = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                act_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            act_cnt_q <= '0;
            gap_cnt_q <= '0;
            gap_lat_q <= '0;
            sel_q     <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            act_cnt_q <= act_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            gap_lat_q <= gap_lat_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_starter_sel_ctrl.sv
// Scoreboard bench for starter_sel_ctrl: a window-level model predicts each
// grant, a monitor checks every window, its done pulse and its guard gap.
module tb_starter_sel_ctrl;

    localparam int N_REQ  = 4;
    localparam int HOLD_W = 8;
    localparam int GAP_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N_REQ-1:0]  req = '0;
    logic [HOLD_W-1:0] hold_len = '0;
    logic [GAP_W-1:0]  gap_len = '0;
    logic              sel;
    logic [N_REQ-1:0]  gnt;
    logic              busy;
    logic              done;

    starter_sel_ctrl #(.N_REQ(N_REQ), .HOLD_W(HOLD_W), .GAP_W(GAP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .hold_len (hold_len),
        .gap_len  (gap_len),
        .sel      (sel),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0] gnt;
        int               hold;
        int               gap;
    } win_t;

    win_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   mon_busy = 1'b0;
    bit   model_en = 1'b1;
    int   edge_no = 0;
    int   next_eval = 0;
    int   ptr_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle of inputs; the model decides whether the coming edge grants.
    task automatic step(input logic [N_REQ-1:0] r, input logic [HOLD_W-1:0] h,
                        input logic [GAP_W-1:0] g);
        win_t w;
        bit   found;
        @(negedge clk);
        req = r;
        hold_len = h;
        gap_len = g;
        if (model_en && edge_no >= next_eval && r != '0) begin
            found = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                int idx;
                idx = (ptr_m + k) % N_REQ;
                if (!found && r[idx]) begin
                    found = 1'b1;
                    w.gnt = '0;
                    w.gnt[idx] = 1'b1;
                    ptr_m = (idx + 1) % N_REQ;
                end
            end
            w.hold = (h == '0) ? 1 : int'(h);
            w.gap  = int'(g);
            exp_q.push_back(w);
            next_eval = edge_no + w.hold + w.gap + 1;
        end
        edge_no++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 500) begin
            step('0, '0, '0);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        step('0, '0, '0);
    endtask

    // Monitor: consumes one predicted window each time sel rises.
    initial begin
        win_t e;
        int   len;
        int   waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("gnt_not_multihot", 32'($countones(gnt) <= 1), 32'd1);
                if (sel) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_window", 32'(sel), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        mon_busy = 1'b1;
                        waited = 0;
                        chk("win_gnt", 32'(gnt), 32'(e.gnt));
                        chk("win_busy", 32'(busy), 32'd1);
                        len = 1;
                        @(negedge clk);
                        while (sel === 1'b1 && len < 300) begin
                            chk("win_gnt_const", 32'(gnt), 32'(e.gnt));
                            chk("win_busy", 32'(busy), 32'd1);
                            len++;
                            @(negedge clk);
                        end
                        chk("win_len", 32'(len), 32'(e.hold));
                        for (int k = 0; k <= e.gap; k++) begin
                            if (k > 0) @(negedge clk);
                            chk("gap_sel_low", 32'(sel), 32'd0);
                            chk("gap_gnt_zero", 32'(gnt), 32'd0);
                            chk("done_pulse", 32'(done), 32'(k == 0));
                            chk("gap_busy", 32'(busy), 32'(k < e.gap));
                        end
                        mon_busy = 1'b0;
                    end
                end else begin
                    chk("idle_done_low", 32'(done), 32'd0);
                    chk("idle_busy_low", 32'(busy), 32'd0);
                    chk("idle_gnt_zero", 32'(gnt), 32'd0);
                    if (exp_q.size() > 0) begin
                        waited++;
                        if (waited > 300) begin
                            chk("window_timeout", 32'd0, 32'd1);
                            void'(exp_q.pop_front());
                            waited = 0;
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, randomized traffic, then reset mid-window.
    initial begin
        logic [N_REQ-1:0] r;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            edge_no++;
        end
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        req = '0;
        next_eval = edge_no;
        ptr_m = 0;
        edge_no++;
        mon_en = 1'b1;

        repeat (8) step(4'b0001, 8'd3, 4'd2);
        repeat (10) step(4'b1111, 8'd1, 4'd0);
        drain();
        repeat (3) step(4'b0100, 8'd0, 4'd1);
        drain();
        step(4'b0010, 8'd5, 4'd1);
        repeat (10) step(4'b0000, 8'd1, 4'd0);
        drain();

        for (int i = 0; i < 300; i++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 3) r = '0;
            step(r, 8'($urandom_range(0, 6)), 4'($urandom_range(0, 3)));
        end
        drain();

        mon_en = 1'b0;
        model_en = 1'b0;
        step(4'b0001, 8'd4, 4'd1);
        @(negedge clk);
        chk("mid_rst_act1_sel", 32'(sel), 32'd1);
        chk("mid_rst_act1_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        chk("mid_rst_act2_sel", 32'(sel), 32'd1);
        rst = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt_ptr0", 32'(gnt), 32'h1);
        chk("post_rst_sel", 32'(sel), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
